// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
package reset_seq_pkg;

  // Sequencer phases: hold all resets, wait for a stage ack, inter-stage gap,
  // fully released, and ack-timeout fault.
  typedef enum logic [2:0] {
    ASSERT   = 3'd0,
    WAIT_ACK = 3'd1,
    GAP      = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } seq_state_e;

  // Width of a stage index; never narrower than one bit.
  function automatic int stg_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Stage-reset bundle between the sequencer (slave) and the SoC/stages (master).
// Handshake: each stage_rst[i] falls once; the stage answers by raising
// stage_ack[i] (level, synchronous to clk) and holds it; the sequencer samples
// stage_ack[i] only while waiting on stage i, so early or late acks are both
// legal, and acks are ignored once the whole sequence is done.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int STG_W      = reset_seq_pkg::stg_w(NUM_STAGES)
);
  import reset_seq_pkg::*;

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic                  seq_fault;
  logic [STG_W-1:0]      fault_stage;
  seq_state_e            dbg_state;

  modport master (
    output soft_rst_req, stage_ack,
    input  stage_rst, seq_done, seq_fault, fault_stage, dbg_state
  );

  modport slave (
    input  soft_rst_req, stage_ack,
    output stage_rst, seq_done, seq_fault, fault_stage, dbg_state
  );

endinterface

// File: rtl/seq_timer.sv
// Shared cycle counter for hold, gap and ack-timeout phases. The terminal
// count flag compares the current count against a limit chosen by the FSM.
module seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Count up while enabled; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release sequencer: holds every stage in reset for a minimum
// time, then releases stages one at a time, each after the previous stage
// acknowledged plus a gap. Reports completion and ack timeouts.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  localparam int STG_W = stg_w(NUM_STAGES);
  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(GAP_CYCLES - 1);
  // With timeout disabled the limit is unused; the counter simply wraps.
  localparam logic [CNT_W-1:0] L_ACK  = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [STG_W-1:0] LAST_IDX = STG_W'(NUM_STAGES - 1);

  seq_state_e            r_state;
  logic [STG_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_done;
  logic                  r_fault;
  logic [STG_W-1:0]      r_fault_stage;

  seq_state_e            w_state_nxt;
  logic [STG_W-1:0]      w_idx_nxt;
  logic [STG_W-1:0]      w_idx_inc;
  logic [NUM_STAGES-1:0] w_stage_rst_nxt;
  logic                  w_done_nxt;
  logic                  w_fault_nxt;
  logic [STG_W-1:0]      w_fault_stage_nxt;
  logic                  w_tmr_clr;
  logic                  w_tmr_en;
  logic [CNT_W-1:0]      w_tmr_limit;
  logic                  w_tmr_tc;

  assign w_idx_inc = r_idx + STG_W'(1);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_limit (w_tmr_limit),
    .o_tc    (w_tmr_tc)
  );

  // Terminal-count limit for the phase currently being timed.
  always_comb begin
    w_tmr_limit = L_HOLD;
    case (r_state)
      WAIT_ACK: w_tmr_limit = L_ACK;
      GAP:      w_tmr_limit = L_GAP;
      default:  w_tmr_limit = L_HOLD;
    endcase
  end

  // Next state, timer control and next output values; soft request wins
  // over everything in the current state, ack acceptance wins over timeout.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_stage_rst_nxt   = r_stage_rst;
    w_done_nxt        = r_done;
    w_fault_nxt       = r_fault;
    w_fault_stage_nxt = r_fault_stage;
    w_tmr_clr         = 1'b0;
    w_tmr_en          = 1'b0;

    if (bus.soft_rst_req) begin
      w_state_nxt     = ASSERT;
      w_idx_nxt       = '0;
      w_stage_rst_nxt = '1;
      w_done_nxt      = 1'b0;
      w_fault_nxt     = 1'b0;
      w_tmr_clr       = 1'b1;
    end else begin
      case (r_state)
        ASSERT: begin
          w_stage_rst_nxt = '1;
          if (w_tmr_tc) begin
            w_stage_rst_nxt[0] = 1'b0;
            w_tmr_clr          = 1'b1;
            w_state_nxt        = WAIT_ACK;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (bus.stage_ack[r_idx]) begin
            w_tmr_clr = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = RUN;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = GAP;
            end
          end else if (TIMEOUT_EN && w_tmr_tc) begin
            w_state_nxt       = FAULT;
            w_stage_rst_nxt   = '1;
            w_fault_nxt       = 1'b1;
            w_fault_stage_nxt = r_idx;
            w_tmr_clr         = 1'b1;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        GAP: begin
          if (w_tmr_tc) begin
            w_idx_nxt                  = w_idx_inc;
            w_stage_rst_nxt[w_idx_inc] = 1'b0;
            w_tmr_clr                  = 1'b1;
            w_state_nxt                = WAIT_ACK;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        default: begin
          // RUN and FAULT park here until a soft request or rst.
          w_tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // State, index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ASSERT;
      r_idx         <= '0;
      r_stage_rst   <= '1;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_stage <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_stage_rst   <= w_stage_rst_nxt;
      r_done        <= w_done_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_stage <= w_fault_stage_nxt;
    end
  end

  assign bus.stage_rst   = r_stage_rst;
  assign bus.seq_done    = r_done;
  assign bus.seq_fault   = r_fault;
  assign bus.fault_stage = r_fault_stage;
  assign bus.dbg_state   = r_state;

endmodule
